// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
// Optional signed overflow output: define SERIAL_ADDSUB_OVF_EN.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/addsub_bit_cell.sv
// One-bit full adder / full subtractor; c is carry-in or borrow-in.
module addsub_bit_cell
  import serial_addsub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic mode,
  output logic s,
  output logic c_next
);

  always_comb begin
    s = a ^ b ^ c;
    if (mode == MODE_ADD) begin
      c_next = (a & b) | (a & c) | (b & c);
    end else begin
      c_next = (~a & b) | (~(a ^ b) & c);
    end
  end

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller, LSB first, one bit per RUN cycle.
// Define SERIAL_ADDSUB_OVF_EN to add the signed overflow output ovf.
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             cb_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             c_q, c_d;
  logic             s_bit, c_nx;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  addsub_bit_cell u_cell (
    .a      (a_q[0]),
    .b      (b_q[0]),
    .c      (c_q),
    .mode   (mode_q),
    .s      (s_bit),
    .c_next (c_nx)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    c_d     = c_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          cnt_d   = '0;
          c_d     = 1'b0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = c_nx;
        res_d = {s_bit, res_q[WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
`ifdef SERIAL_ADDSUB_OVF_EN
          // carry into the MSB is c_q, carry out of it is c_nx
          ovf_d   = c_q ^ c_nx;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign cb_out = c_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl with an arithmetic reference model.
// Build with SERIAL_ADDSUB_OVF_EN defined to also score ovf.
module tb_serial_addsub_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         cb;
    logic         ov;
    int           done_edge;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cb_out;
  logic [W-1:0] result;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic         ovf;
`endif

  serial_addsub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
`ifdef SERIAL_ADDSUB_OVF_EN
    .ovf    (ovf),
`endif
    .cb_out (cb_out)
  );

  always #5 clk = ~clk;

  int   edges = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   next_free = 1 << 30;
  int   cur_acc = -100;
  exp_t sb[$];
  logic [W-1:0] held_res = '0;
  logic         held_cb = 1'b0;
  logic         held_ov = 1'b0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h",
               name, edges, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int ia, input int ib, input logic m);
    exp_t e;
    int   sa, sb2, sr, r;
    sa  = (ia >= (1 << (W-1))) ? ia - (1 << W) : ia;
    sb2 = (ib >= (1 << (W-1))) ? ib - (1 << W) : ib;
    if (m) begin
      r    = ia + ib;
      e.cb = (r >= (1 << W));
      sr   = sa + sb2;
    end else begin
      r    = ia - ib;
      e.cb = (ia < ib);
      sr   = sa - sb2;
    end
    e.res = W'(r & ((1 << W) - 1));
    e.ov  = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    e.done_edge = 0;
    return e;
  endfunction

  task automatic drive(input logic st, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic im,
                       output logic acc);
    exp_t e;
    @(negedge clk);
    start = st;
    a     = ia;
    b     = ib;
    mode  = im;
    acc   = 1'b0;
    if (st && !rst && (edges + 1 >= next_free)) begin
      e = model(int'(ia), int'(ib), im);
      e.done_edge = edges + 1 + W;
      sb.push_back(e);
      cur_acc   = edges + 1;
      next_free = edges + 1 + W + 2;
      acc       = 1'b1;
    end
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                    input logic im, input int n_after, input logic noisy);
    logic acc;
    int   tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 50) begin
      drive(1'b1, ia, ib, im, acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
    for (int i = 0; i < n_after; i++) begin
      if (noisy)
        drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), acc);
      else
        drive(1'b0, W'($urandom), W'($urandom), 1'($urandom), acc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_cb"}, int'(cb_out), 0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({tag, "_ovf"}, int'(ovf), 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    sb.delete();
    cur_acc  = -100;
    held_res = '0;
    held_cb  = 1'b0;
    held_ov  = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    check_zero("rst_hold");
    rst = 1'b0;
    next_free = edges + 1;
  endtask

  // Monitor: pops the scoreboard on done, tracks busy and held outputs.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("busy", int'(busy),
          int'(edges >= cur_acc && edges < cur_acc + W));
      if (sb.size() > 0 && edges > sb[0].done_edge) begin
        e = sb.pop_front();
        chk("done_missing", 0, 1);
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_edge", edges, e.done_edge);
          chk("result", int'(result), int'(e.res));
          chk("cb_out", int'(cb_out), int'(e.cb));
`ifdef SERIAL_ADDSUB_OVF_EN
          chk("ovf", int'(ovf), int'(e.ov));
`endif
          held_res = e.res;
          held_cb  = e.cb;
          held_ov  = e.ov;
        end
      end else if (!(edges >= cur_acc && edges < cur_acc + W)) begin
        chk("held_result", int'(result), int'(held_res));
        chk("held_cb", int'(cb_out), int'(held_cb));
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("held_ovf", int'(ovf), int'(held_ov));
`endif
      end
    end
  end

  initial begin
    logic acc;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    next_free = edges + 1;

    op(8'h3C, 8'h0F, 1'b1, W + 1, 1'b0);
    op(8'hFF, 8'h01, 1'b1, W + 1, 1'b0);
    op(8'h7F, 8'h01, 1'b1, W + 1, 1'b0);
    op(8'h05, 8'h07, 1'b0, W + 1, 1'b0);
    op(8'h80, 8'h01, 1'b0, W + 1, 1'b0);

    // start and operands toggled while running must be ignored
    op(8'hA5, 8'h5A, 1'b1, W + 1, 1'b1);
    op(8'h00, 8'h01, 1'b0, W + 1, 1'b1);

    // abort mid-run, then the next start must be accepted at once
    op(8'h11, 8'h22, 1'b1, 3, 1'b0);
    do_reset();
    op(8'h10, 8'h20, 1'b1, W + 1, 1'b0);

    // start held high continuously
    repeat (35) drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), acc);

    repeat (400) begin
      drive(($urandom_range(0, 3) == 0), W'($urandom), W'($urandom),
            1'($urandom), acc);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    repeat (W + 4) drive(1'b0, '0, '0, 1'b0, acc);
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port mode, input, 1 bit: 1 selects add, 0 selects subtract (a-b); latched at accept.
REQ-006 SHALL have ports a and b, input, WIDTH bits each: operands, latched at accept.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-009 SHALL have port result, output, WIDTH bits: sum or difference.
REQ-010 SHALL have port cb_out, output, 1 bit: final carry (add) or final borrow (subtract).

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 Transitions SHALL be: IDLE->RUN on an edge with start=1; RUN->DONE after WIDTH RUN edges; DONE->IDLE unconditionally.
REQ-013 At accept, the block SHALL load a and b into shift registers, latch mode, clear the bit counter and clear the carry/borrow register.
REQ-014 Each RUN edge SHALL process one bit, LSB first, and shift the resulting bit into result from the MSB end.
REQ-015 Add bit SHALL be a^b^c, with c_next=(a&b)|(a&c)|(b&c).
REQ-016 Subtract bit SHALL be a^b^c, with c_next=(~a&b)|(~(a^b)&c).
REQ-017 With start accepted at edge E0, busy SHALL be high from E0 to E(WIDTH), and done SHALL be high from E(WIDTH) to E(WIDTH+1) only.
REQ-018 result and cb_out SHALL be valid when done=1 and SHALL hold until the next accept.
REQ-019 start in RUN or DONE SHALL be ignored and not queued; changes to mode, a or b after accept SHALL have no effect.
REQ-020 Results SHALL be modulo 2^WIDTH; cb_out=1 SHALL indicate unsigned overflow (add) or a>b false with a<b (subtract: borrow when a<b unsigned).
REQ-021 The bit counter SHALL be $clog2(WIDTH) bits and SHALL NOT wrap during RUN.

Reset
REQ-022 While rst=1, state SHALL be IDLE and busy, done, result, cb_out, the counter, the carry register and the shift registers SHALL all be 0.
REQ-023 rst asserted mid-RUN SHALL abort the operation immediately, with no done pulse.
REQ-024 After rst deasserts, the first start SHALL be accepted on the first edge.

Configuration
REQ-025 With macro SERIAL_ADDSUB_OVF_EN defined, the block SHALL add output ovf (1 bit): signed two's-complement overflow, equal to the carry into the MSB XOR the carry/borrow out of the MSB. ovf SHALL be valid and held with result, and SHALL reset to 0.
REQ-026 With SERIAL_ADDSUB_OVF_EN undefined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-027 Package serial_addsub_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the constants MODE_ADD=1 and MODE_SUB=0.
REQ-028 The per-bit combinational full add/subtract cell SHALL be sub-module addsub_bit_cell (inputs a, b, c, mode; outputs s, c_next), instantiated once.

Verification (WIDTH=8)
REQ-029 Add: a=0x3C, b=0x0F, start at E0 -> done at E8 only, result=0x4B, cb_out=0, ovf=0.
REQ-030 Add: a=0xFF, b=0x01 -> result=0x00, cb_out=1, ovf=0; a=0x7F, b=0x01 -> result=0x80, cb_out=0, ovf=1.
REQ-031 Sub: a=0x05, b=0x07 -> result=0xFE, cb_out=1, ovf=0; a=0x80, b=0x01 -> result=0x7F, cb_out=0, ovf=1.
REQ-032 start re-asserted at E3 with new operands during RUN -> ignored, first result unchanged, exactly one done pulse.
REQ-033 rst pulsed at E4 of an operation -> all outputs 0 immediately, no done pulse; next start (0x10+0x20) -> result=0x30 at E8 from its accept.
REQ-034 Back-to-back: start held high continuously -> accepts every WIDTH+2 edges (E0, E10, ...), one done per operation.
